// File: rtl/lcd_timing_gen_pkg.sv
// Shared types and default panel timing for the LCD timing generator.
package lcd_timing_pkg;

   // Controller states: wait for lock, qualify lock, scan, finish frame after disable
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_QUAL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Default timing for the 480x272 panel
   localparam int DEF_H_ACTIVE    = 480;
   localparam int DEF_H_FP        = 8;
   localparam int DEF_H_SYNC      = 4;
   localparam int DEF_H_BP        = 43;
   localparam int DEF_V_ACTIVE    = 272;
   localparam int DEF_V_FP        = 4;
   localparam int DEF_V_SYNC      = 4;
   localparam int DEF_V_BP        = 12;
   localparam int DEF_LOCK_CYCLES = 1024;

   // Period of one axis: visible region plus the three blanking segments
   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Panel-control bundle between the timing generator and the pixel-drive stage.
interface lcd_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          en;
   logic          running;
   logic          de;
   logic          hsync;
   logic          vsync;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          frame_start;

   // Timing generator side
   modport master (input en, output running, de, hsync, vsync, x, y, frame_start);
   // Consumer / controller side
   modport slave  (output en, input running, de, hsync, vsync, x, y, frame_start);
endinterface

// File: rtl/lcd_timing_gen_lock_qualifier.sv
// Synchronizes the PLL lock flag and counts consecutive high samples.
module lock_qualifier #(
   parameter int LOCK_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_locked,
   input  logic i_count_en,
   output logic o_lock_s,
   output logic o_lock_ok
);
   localparam int            CW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic [CW-1:0] r_cnt;

   // Two-flop synchronizer for the asynchronous lock flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_locked;
         r_sync <= r_meta;
      end
   end

   // Counts high samples already seen; any low sample or disabled counting restarts it
   always_ff @(posedge clk) begin
      if (rst || !i_count_en || !r_sync) begin
         r_cnt <= '0;
      end else if (r_cnt != LAST) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_lock_s  = r_sync;
   // The current high sample is the LOCK_CYCLES-th in a row
   assign o_lock_ok = r_sync && (r_cnt == LAST);
endmodule

// File: rtl/lcd_timing_gen.sv
// HSYNC/VSYNC/DE timing generator gated by a qualified PLL lock.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE        = DEF_H_ACTIVE,
   parameter int H_FP            = DEF_H_FP,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BP            = DEF_H_BP,
   parameter int V_ACTIVE        = DEF_V_ACTIVE,
   parameter int V_FP            = DEF_V_FP,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BP            = DEF_V_BP,
   parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int XW              = 10,
   parameter int YW              = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              locked,
   lcd_timing_gen_if.master  bus
);
   localparam int   H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int   V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int   HS_START  = H_ACTIVE + H_FP;
   localparam int   HS_END    = HS_START + H_SYNC;
   localparam int   VS_START  = V_ACTIVE + V_FP;
   localparam int   VS_END    = VS_START + V_SYNC;
   localparam int   HW        = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int   VW        = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

   state_t          r_state, w_state_next;
   logic [HW-1:0]   r_h, w_h_next;
   logic [VW-1:0]   r_v, w_v_next;
   logic            r_running, r_de, r_hsync, r_vsync, r_frame_start;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic            w_lock_s, w_lock_ok, w_count_en;
   logic            w_scan, w_scan_next, w_frame_end;
   logic            w_de, w_hs_on, w_vs_on;

   // Lock counting runs only while waiting to start with the run request present
   assign w_count_en = bus.en && (r_state == ST_IDLE || r_state == ST_QUAL);

   lock_qualifier #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_qualifier (
      .clk        (clk),
      .rst        (rst),
      .i_locked   (locked),
      .i_count_en (w_count_en),
      .o_lock_s   (w_lock_s),
      .o_lock_ok  (w_lock_ok)
   );

   assign w_scan      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_frame_end = (32'(r_h) == H_TOTAL - 1) && (32'(r_v) == V_TOTAL - 1);

   // Next state; lock loss dominates every other condition
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:
            if (w_lock_s && bus.en) w_state_next = w_lock_ok ? ST_RUN : ST_QUAL;
         ST_QUAL:
            if (!w_lock_s || !bus.en) w_state_next = ST_IDLE;
            else if (w_lock_ok)       w_state_next = ST_RUN;
         ST_RUN:
            // A disable seen on the last frame cycle has nothing left to drain
            if (!w_lock_s)    w_state_next = ST_IDLE;
            else if (!bus.en) w_state_next = w_frame_end ? ST_IDLE : ST_DRAIN;
         ST_DRAIN:
            if (!w_lock_s)        w_state_next = ST_IDLE;
            else if (bus.en)      w_state_next = ST_RUN;
            else if (w_frame_end) w_state_next = ST_IDLE;
         default:
            w_state_next = ST_IDLE;
      endcase
   end

   assign w_scan_next = (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);

   // Next raster position: starts at (0,0) on entry, advances while scanning, else cleared
   always_comb begin
      w_h_next = '0;
      w_v_next = '0;
      if (w_scan_next && w_scan) begin
         if (32'(r_h) == H_TOTAL - 1) begin
            w_h_next = '0;
            w_v_next = (32'(r_v) == V_TOTAL - 1) ? '0 : r_v + 1'b1;
         end else begin
            w_h_next = r_h + 1'b1;
            w_v_next = r_v;
         end
      end
   end

   // Decode from the next position so registered outputs line up with their counters
   assign w_de    = w_scan_next && (32'(w_h_next) < H_ACTIVE) && (32'(w_v_next) < V_ACTIVE);
   assign w_hs_on = w_scan_next && (32'(w_h_next) >= HS_START) && (32'(w_h_next) < HS_END);
   assign w_vs_on = w_scan_next && (32'(w_v_next) >= VS_START) && (32'(w_v_next) < VS_END);

   // State, counters and all panel outputs registered together
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_h           <= '0;
         r_v           <= '0;
         r_running     <= 1'b0;
         r_de          <= 1'b0;
         r_hsync       <= SYNC_IDLE;
         r_vsync       <= SYNC_IDLE;
         r_x           <= '0;
         r_y           <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_h           <= w_h_next;
         r_v           <= w_v_next;
         // Stays high through a drain; drops with the first idle cycle
         r_running     <= w_scan_next;
         r_de          <= w_de;
         r_hsync       <= w_hs_on ^ SYNC_IDLE;
         r_vsync       <= w_vs_on ^ SYNC_IDLE;
         r_x           <= w_de ? XW'(w_h_next) : '0;
         r_y           <= w_de ? YW'(w_v_next) : '0;
         r_frame_start <= w_scan_next && (w_h_next == '0) && (w_v_next == '0);
      end
   end

   assign bus.running     = r_running;
   assign bus.de          = r_de;
   assign bus.hsync       = r_hsync;
   assign bus.vsync       = r_vsync;
   assign bus.x           = r_x;
   assign bus.y           = r_y;
   assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a small 8x6 raster with LOCK_CYCLES=4.
module tb_lcd_timing_gen;
   localparam int XW = 10;
   localparam int YW = 9;

   logic clk = 1'b0;
   logic rst;
   logic locked;

   lcd_timing_gen_if #(.XW(XW), .YW(YW)) bus ();

   lcd_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .LOCK_CYCLES(4), .SYNC_ACTIVE_LOW(1'b1), .XW(XW), .YW(YW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .locked (locked),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          running;
      logic          de;
      logic          hsync;
      logic          vsync;
      logic          fs;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  val;
      bit    chk_running;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   fs_seen     = 0;
   int   de_seen     = 0;

   // Expected idle output cycle
   task automatic push_idle(input string tag);
      exp_t e;
      e.tag         = tag;
      e.val.running = 1'b0;
      e.val.de      = 1'b0;
      e.val.hsync   = 1'b1;
      e.val.vsync   = 1'b1;
      e.val.fs      = 1'b0;
      e.val.x       = '0;
      e.val.y       = '0;
      e.chk_running = 1'b1;
      sb.push_back(e);
   endtask

   // Expected scanning cycle at raster position (h,v): H 4/1/2/1, V 3/1/1/1
   task automatic push_px(input string tag, input int h, input int v, input bit chk_run);
      exp_t e;
      bit   vis;
      vis           = (h < 4) && (v < 3);
      e.tag         = tag;
      e.val.running = 1'b1;
      e.val.de      = vis;
      e.val.hsync   = !(h == 5 || h == 6);
      e.val.vsync   = !(v == 4);
      e.val.fs      = (h == 0) && (v == 0);
      e.val.x       = vis ? XW'(h) : '0;
      e.val.y       = vis ? YW'(v) : '0;
      e.chk_running = chk_run;
      sb.push_back(e);
   endtask

   // One clock: sample away from the edge, pop the expectation and compare
   task automatic step();
      exp_t e;
      obs_t o;
      @(posedge clk);
      #1;
      o.running = bus.running;
      o.de      = bus.de;
      o.hsync   = bus.hsync;
      o.vsync   = bus.vsync;
      o.fs      = bus.frame_start;
      o.x       = bus.x;
      o.y       = bus.y;
      if (o.fs) fs_seen++;
      if (o.de) de_seen++;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL sb_underflow obs=%h required=<none>", o);
      end else begin
         e = sb.pop_front();
         if (!e.chk_running) o.running = e.val.running;
         $display("%0t %s run=%b de=%b hs=%b vs=%b fs=%b x=%0d y=%0d",
                  $time, e.tag, o.running, o.de, o.hsync, o.vsync, o.fs, o.x, o.y);
         assert (o === e.val) else begin
            miscompares++;
            $error("FAIL %s obs=%h required=%h", e.tag, o, e.val);
         end
      end
   endtask

   // Aggregate count check
   task automatic check_count(input string tag, input int obs, input int req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s obs=%0d required=%0d", tag, obs, req);
      end
   endtask

   initial begin
      rst    = 1'b1;
      locked = 1'b1;
      bus.en = 1'b0;

      // Reset and idle with lock present but no run request
      repeat (3) begin push_idle("reset"); step(); end
      rst = 1'b0;
      repeat (20) begin push_idle("idle_en0"); step(); end

      // Drop lock, then request run before lock returns
      locked = 1'b0;
      repeat (4) begin push_idle("unlock"); step(); end
      bus.en = 1'b1;
      repeat (2) begin push_idle("en_nolock"); step(); end

      // Lock qualification: lock sampled at edge k, first RUN output after edge k+5
      locked = 1'b1;
      repeat (5) begin push_idle("qual"); step(); end

      // First RUN cycle and the full frame that follows
      de_seen = 0;
      fs_seen = 0;
      for (int i = 0; i < 48; i++) begin push_px("frame", i % 8, i / 8, 1'b1); step(); end
      check_count("frame_de_count", de_seen, 12);
      check_count("frame_fs_count", fs_seen, 1);
      push_px("frame2_start", 0, 0, 1'b1); step();

      // Loss of lock mid-frame at (2,1)
      for (int i = 1; i <= 10; i++) begin push_px("pre_loss", i % 8, i / 8, 1'b1); step(); end
      locked = 1'b0;
      push_px("loss_tail", 3, 1, 1'b1); step();
      push_px("loss_tail", 4, 1, 1'b1); step();
      repeat (5) begin push_idle("lost"); step(); end

      // Re-lock restarts at (0,0)
      locked = 1'b1;
      repeat (5) begin push_idle("relock_qual"); step(); end
      push_px("relock_start", 0, 0, 1'b1); step();

      // Drop lock again, then glitch it during qualification
      locked = 1'b0;
      push_px("loss2_tail", 1, 0, 1'b1); step();
      push_px("loss2_tail", 2, 0, 1'b1); step();
      repeat (4) begin push_idle("lost2"); step(); end
      locked = 1'b1;
      repeat (3) begin push_idle("glitch_hi"); step(); end
      locked = 1'b0;
      push_idle("glitch_lo"); step();
      locked = 1'b1;
      repeat (5) begin push_idle("glitch_requal"); step(); end
      push_px("glitch_run", 0, 0, 1'b1); step();

      // Disable at v=1: drain to (7,5), then idle with no further frame start
      fs_seen = 0;
      for (int i = 1; i <= 8; i++) begin push_px("pre_dis", i % 8, i / 8, 1'b1); step(); end
      bus.en = 1'b0;
      for (int i = 9; i < 48; i++) begin push_px("drain", i % 8, i / 8, 1'b0); step(); end
      repeat (10) begin push_idle("drained"); step(); end
      check_count("drain_fs_count", fs_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
